seg_scan_driver: RTL and testbench

- Time-multiplexed driver for the 8-digit common-anode seven-segment display on the board.
- Complements the key debouncer: that block conditions human input, this block produces human-readable output.
- Accepts a 32-bit hex value, per-digit decimal points and a digit-enable mask through a load strobe.
- Scans one digit at a time, with a blanking gap between digits to suppress ghosting. Updates are applied only at frame boundaries, so no displayed frame ever mixes old and new values.

---
 rtl/seg_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit slot is a short blanking gap followed by an ON window. New values
// are captured into a shadow set on load_i and copied into the displayed
// (active) set only at the end of a full frame, so a frame never mixes old and
// new data. All outputs are registered.
module seg_scan_driver #(
  parameter logic [19:0] SCAN_CNT_MAX = 20'd99_999,  // ON cycles per digit minus 1
  parameter logic [19:0] BLANK_CNT    = 20'd999      // blank cycles per digit minus 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_i,
  input  logic        load_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [7:0]  an_o,
  output logic        frame_o
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // Scan control
  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        frame_end;

  // Shadow set (written by load_i) and active set (what is on the display)
  logic [31:0] shadow_data_q;
  logic [7:0]  shadow_dp_q;
  logic [7:0]  shadow_en_q;
  logic [31:0] active_data_q;
  logic [7:0]  active_dp_q;
  logic [7:0]  active_en_q;

  // Per-digit views of the active set, selected by the upcoming digit index
  logic [3:0]  nibble [8];
  logic [7:0]  digit_sel;
  logic [3:0]  cur_nibble;
  logic        cur_en;
  logic        cur_dp;

  // Next values for the registered outputs
  logic [7:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;

  // Hex nibble to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Split the active word into digits and build a one-hot of the next digit
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    assign nibble[gi]    = active_data_q[4*gi +: 4];
    assign digit_sel[gi] = (idx_d == 3'(gi));
  end

  assign cur_nibble = nibble[idx_d];
  assign cur_en     = active_en_q[idx_d];
  assign cur_dp     = active_dp_q[idx_d];

  // The last ON cycle of digit 7 closes the frame
  assign frame_end = (state_q == ST_ON) && (cnt_q == SCAN_CNT_MAX) && (idx_q == 3'd7);

  // Next-state logic for the blank/ON scan sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 20'd1;
    idx_d   = idx_q;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_CNT) begin
          state_d = ST_ON;
          cnt_d   = 20'd0;
        end
      end
      default: begin
        if (cnt_q == SCAN_CNT_MAX) begin
          state_d = ST_BLANK;
          cnt_d   = 20'd0;
          idx_d   = idx_q + 3'd1;
        end
      end
    endcase
  end

  // Output values for the state being entered; a disabled digit stays dark.
  // The active set is stable whenever ST_ON is entered, since it only changes
  // on the edge that enters ST_BLANK.
  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((state_d == ST_ON) && cur_en) begin
      an_d  = ~digit_sel;
      seg_d = hex_to_seg(cur_nibble);
      dp_d  = ~cur_dp;
    end
  end

  // Scan FSM with registered outputs, updated on the same edge as state/idx
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= 20'd0;
      idx_q   <= 3'd0;
      an_o    <= 8'hFF;
      seg_o   <= 7'h7F;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_o    <= an_d;
      seg_o   <= seg_d;
      dp_o    <= dp_d;
      frame_o <= frame_end;
    end
  end

  // Shadow capture on load; active takes the pre-edge shadow at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_data_q <= 32'd0;
      shadow_dp_q   <= 8'd0;
      shadow_en_q   <= 8'd0;
      active_data_q <= 32'd0;
      active_dp_q   <= 8'd0;
      active_en_q   <= 8'd0;
    end else begin
      if (load_i) begin
        shadow_data_q <= data_i;
        shadow_dp_q   <= dp_i;
        shadow_en_q   <= en_i;
      end
      if (frame_end) begin
        active_data_q <= shadow_data_q;
        active_dp_q   <= shadow_dp_q;
        active_en_q   <= shadow_en_q;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with short timing (12-cycle digit, 96-cycle frame).
// Cycle t counts clock edges since reset release; expected outputs for each t
// are pushed to a scoreboard queue and compared at the following falling edge.
module tb_seg_scan_driver;

  localparam logic [19:0] SCAN_MAX  = 20'd9;
  localparam logic [19:0] BLANK_MAX = 20'd1;
  localparam int DIGIT_P   = 12;
  localparam int FRAME_P   = 96;
  localparam int BLANK_LEN = 2;
  localparam int ON_LEN    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_i = 32'd0;
  logic [7:0]  dp_i = 8'd0;
  logic [7:0]  en_i = 8'd0;
  logic        load_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [7:0]  an_o;
  logic        frame_o;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         t;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t sb[$];

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_driver #(
    .SCAN_CNT_MAX(SCAN_MAX),
    .BLANK_CNT   (BLANK_MAX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .dp_i   (dp_i),
    .en_i   (en_i),
    .load_i (load_i),
    .seg_o  (seg_o),
    .dp_o   (dp_o),
    .an_o   (an_o),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected outputs after edge t for a given displayed (active) set
  function automatic exp_t model(int t, logic [31:0] d, logic [7:0] p, logic [7:0] e);
    exp_t r;
    int dig;
    logic [3:0] nib;
    dig     = (t / DIGIT_P) % 8;
    r.t     = t;
    r.an    = 8'hFF;
    r.seg   = 7'h7F;
    r.dp    = 1'b1;
    r.frame = (t > 0) && (t % FRAME_P == 0);
    if ((t % DIGIT_P) >= BLANK_LEN && e[dig]) begin
      nib       = d[dig*4 +: 4];
      r.an[dig] = 1'b0;
      r.seg     = dec_tab[nib];
      r.dp      = ~p[dig];
    end
    return r;
  endfunction

  task automatic push_range(int t0, int t1, logic [31:0] d, logic [7:0] p, logic [7:0] e);
    for (int t = t0; t <= t1; t++) sb.push_back(model(t, d, p, e));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({an_o, seg_o, dp_o, frame_o} !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_state an=%h seg=%h dp=%b frame=%b expected an=ff seg=7f dp=1 frame=0",
               an_o, seg_o, dp_o, frame_o);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cyc !== 1 || {an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1})
      $display("FAIL reset_release t=%0d an=%h seg=%h dp=%b expected t=1 an=ff seg=7f dp=1",
               cyc, an_o, seg_o, dp_o);
    else n_pass++;
  endtask

  task automatic test_first_load;
    exp_t e;
    push_range(2, 95, 32'd0, 8'd0, 8'd0);
    push_range(96, 191, 32'h89AB_CDEF, 8'h01, 8'hFF);
    while (cyc < 191) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {e.an, e.seg, e.dp, e.frame})
          $display("FAIL first_load t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                   cyc, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.frame);
        else n_pass++;
      end
      load_i = 1'b0;
      if (cyc == 4) begin
        load_i = 1'b1; data_i = 32'h89AB_CDEF; dp_i = 8'h01; en_i = 8'hFF;
      end
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL first_load_drain left=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_enable_mask;
    exp_t e;
    push_range(192, 287, 32'h89AB_CDEF, 8'h01, 8'hFF);
    push_range(288, 383, 32'h0123_4567, 8'hF0, 8'h0F);
    while (cyc < 383) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {e.an, e.seg, e.dp, e.frame})
          $display("FAIL enable_mask t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                   cyc, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.frame);
        else n_pass++;
      end
      load_i = 1'b0;
      if (cyc == 194) begin
        load_i = 1'b1; data_i = 32'hFFFF_FFFF; dp_i = 8'hFF; en_i = 8'hFF;
      end else if (cyc == 199) begin
        load_i = 1'b1; data_i = 32'h0123_4567; dp_i = 8'hF0; en_i = 8'h0F;
      end
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL enable_mask_drain left=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_frame_edge_load;
    exp_t e;
    push_range(384, 479, 32'h0123_4567, 8'hF0, 8'h0F);
    push_range(480, 575, 32'h2222_2222, 8'h00, 8'hFF);
    push_range(576, 671, 32'h1111_1111, 8'h00, 8'hFF);
    while (cyc < 671) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {e.an, e.seg, e.dp, e.frame})
          $display("FAIL frame_edge_load t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                   cyc, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.frame);
        else n_pass++;
      end
      load_i = 1'b0;
      if (cyc == 399) begin
        load_i = 1'b1; data_i = 32'h2222_2222; dp_i = 8'h00; en_i = 8'hFF;
      end else if (cyc == 479) begin
        load_i = 1'b1; data_i = 32'h1111_1111; dp_i = 8'h00; en_i = 8'hFF;
      end
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL frame_edge_load_drain left=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_timing;
    int on_run = 0;
    int blank_run = 0;
    int last_frame = -1;
    int n_frames = 0;
    while (cyc < 959) begin
      @(negedge clk);
      n_checks++;
      if ($countones(~an_o) > 1)
        $display("FAIL anode_exclusive t=%0d an=%h expected at most one low", cyc, an_o);
      else n_pass++;
      if (an_o != 8'hFF) begin
        if (blank_run > 0) begin
          n_checks++;
          if (blank_run != BLANK_LEN)
            $display("FAIL blank_len t=%0d len=%0d expected %0d", cyc, blank_run, BLANK_LEN);
          else n_pass++;
          blank_run = 0;
        end
        on_run++;
      end else begin
        if (on_run > 0) begin
          n_checks++;
          if (on_run != ON_LEN)
            $display("FAIL on_len t=%0d len=%0d expected %0d", cyc, on_run, ON_LEN);
          else n_pass++;
          on_run = 0;
        end
        blank_run++;
      end
      if (frame_o) begin
        n_frames++;
        if (last_frame >= 0) begin
          n_checks++;
          if (cyc - last_frame != FRAME_P)
            $display("FAIL frame_period t=%0d period=%0d expected %0d", cyc, cyc - last_frame, FRAME_P);
          else n_pass++;
        end
        last_frame = cyc;
      end
    end
    n_checks++;
    if (n_frames != 3) $display("FAIL frame_count got=%0d expected 3", n_frames);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan;
    exp_t e;
    push_range(965, 965, 32'h1111_1111, 8'h00, 8'hFF);
    while (cyc < 965) @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if ({an_o, seg_o, dp_o, frame_o} !== {e.an, e.seg, e.dp, e.frame})
      $display("FAIL pre_reset_on t=%0d an=%h seg=%h expected an=%h seg=%h", cyc, an_o, seg_o, e.an, e.seg);
    else n_pass++;
    #2;
    rst = 1'b1;
    load_i = 1'b1; data_i = 32'hDEAD_BEEF; dp_i = 8'hFF; en_i = 8'hFF;
    #1;
    n_checks++;
    if ({an_o, seg_o, dp_o, frame_o} !== {8'hFF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL async_reset an=%h seg=%h dp=%b frame=%b expected an=ff seg=7f dp=1 frame=0",
               an_o, seg_o, dp_o, frame_o);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load_i = 1'b0;
    push_range(1, 120, 32'd0, 8'd0, 8'd0);
    while (cyc < 120) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].t <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if ({an_o, seg_o, dp_o, frame_o} !== {e.an, e.seg, e.dp, e.frame})
          $display("FAIL after_reset t=%0d an=%h seg=%h dp=%b frame=%b expected an=%h seg=%h dp=%b frame=%b",
                   cyc, an_o, seg_o, dp_o, frame_o, e.an, e.seg, e.dp, e.frame);
        else n_pass++;
      end
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL after_reset_drain left=%0d expected 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_first_load;
    test_enable_mask;
    test_frame_edge_load;
    test_timing;
    test_reset_mid_scan;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
